// File: rtl/mem_pkg.sv
// Shared definitions for the byte-organised memory and its word writer.
// Holds the writer FSM encoding, byte/word geometry and the default address width.
package mem_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } state_t;

    // Byte lane handled in a given state; IDLE maps to lane 0 and is never used for a write.
    function automatic logic [1:0] lane_of(input state_t s);
        logic [1:0] lane;
        lane = 2'd0;
        case (s)
            ST_B1:   lane = 2'd1;
            ST_B2:   lane = 2'd2;
            ST_B3:   lane = 2'd3;
            default: lane = 2'd0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_word_writer_if.sv
// Request and byte-memory bus of the word writer.
// Valid/ready: a request transfers on a rising edge where req_valid and req_ready are both high;
// the requester holds req_addr/req_data/req_be stable while req_valid is high and unaccepted.
interface mem_word_writer_if
    import mem_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [AW-1:0]         req_addr;
    logic [WORD_W-1:0]     req_data;
    logic [WORD_BYTES-1:0] req_be;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [BYTE_W-1:0]     mem_wdata;
    logic                  done;
    logic                  err;

    modport master (
        output req_valid, req_addr, req_data, req_be,
        input  req_ready, mem_we, mem_addr, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_be,
        output req_ready, mem_we, mem_addr, mem_wdata, done, err
    );

endinterface

// File: rtl/mem_byte_lane_sel.sv
// Big-endian byte lane selector: lane 0 is bits 31:24 with enable bit 3,
// lane 3 is bits 7:0 with enable bit 0.
module mem_byte_lane_sel
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0]     word,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [1:0]            lane,
    output logic [BYTE_W-1:0]     lane_byte,
    output logic                  lane_en
);

    always_comb begin
        lane_byte = '0;
        lane_en   = 1'b0;
        case (lane)
            2'd0: begin
                lane_byte = word[31:24];
                lane_en   = be[3];
            end
            2'd1: begin
                lane_byte = word[23:16];
                lane_en   = be[2];
            end
            2'd2: begin
                lane_byte = word[15:8];
                lane_en   = be[1];
            end
            default: begin
                lane_byte = word[7:0];
                lane_en   = be[0];
            end
        endcase
    end

endmodule

// File: rtl/mem_word_writer.sv
// Writes one 32-bit word into an 8-bit memory port, one big-endian byte per cycle.
// Optional MEM_WRITER_ALIGN_CHK_EN: unaligned requests are accepted, dropped and flagged on err.
module mem_word_writer
    import mem_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    mem_word_writer_if.slave bus,
    output state_t           dbg_state
);

    state_t                state;
    state_t                nxt;
    logic [AW-1:0]         addr_q;
    logic [WORD_W-1:0]     data_q;
    logic [WORD_BYTES-1:0] be_q;

    logic                  accept;
    logic                  reject;
    logic                  start;
    logic [AW-1:0]         src_addr;
    logic [WORD_W-1:0]     src_data;
    logic [WORD_BYTES-1:0] src_be;
    logic [1:0]            nxt_lane;
    logic [AW-1:0]         nxt_addr;
    logic [BYTE_W-1:0]     lane_byte;
    logic                  lane_en;
    logic                  busy_nxt;

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign dbg_state     = state;

`ifdef MEM_WRITER_ALIGN_CHK_EN
    logic err_q;

    assign reject  = accept && (bus.req_addr[1:0] != 2'b00);
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign start = accept && !reject;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (start) nxt = ST_B0;
            ST_B0:   nxt = ST_B1;
            ST_B1:   nxt = ST_B2;
            ST_B2:   nxt = ST_B3;
            ST_B3:   nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so the byte for the next state is chosen now; in IDLE the
    // request itself feeds the selector so B0 is presented right after the accept edge.
    always_comb begin
        src_addr = addr_q;
        src_data = data_q;
        src_be   = be_q;
        if (state == ST_IDLE) begin
            src_addr = bus.req_addr;
            src_data = bus.req_data;
            src_be   = bus.req_be;
        end
        nxt_lane = lane_of(nxt);
        nxt_addr = src_addr + AW'(nxt_lane);
        busy_nxt = (nxt != ST_IDLE);
    end

    mem_byte_lane_sel u_lane_sel (
        .word      (src_data),
        .be        (src_be),
        .lane      (nxt_lane),
        .lane_byte (lane_byte),
        .lane_en   (lane_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else if (start) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            be_q   <= bus.req_be;
        end
    end

    // Disabled lanes still present address and data; only the strobe is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.mem_we <= busy_nxt && lane_en;
            bus.done   <= (nxt == ST_B3);
            if (busy_nxt) begin
                bus.mem_addr  <= nxt_addr;
                bus.mem_wdata <= lane_byte;
            end
        end
    end

endmodule

// File: tb/tb_mem_word_writer.sv
// Bench for mem_word_writer: directed and random word writes checked against a byte-level
// memory model and an expected-write queue.
module tb_mem_word_writer;
  import mem_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  mem_word_writer_if #(.AW(8)) bus ();

  mem_word_writer #(.AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0]  tb_mem [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // The memory array the writer drives.
  always @(posedge clk) if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe seen on the memory port must be the next expected (addr, byte) pair.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.mem_we === 1'b1) begin
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("write_addr_data", {16'h0, bus.mem_addr, bus.mem_wdata}, {16'h0, exp_q.pop_front()});
    end
  end

  function automatic logic [31:0] dut_word(input logic [7:0] a);
    return {tb_mem[a], tb_mem[a + 8'd1], tb_mem[a + 8'd2], tb_mem[a + 8'd3]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
  endfunction

  task automatic model_push(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    for (int k = 0; k < 4; k++) begin
      if (b[3-k]) begin
        logic [7:0] ea;
        logic [7:0] eb;
        ea = 8'((int'(a) + k) % 256);
        eb = 8'((d >> (8 * (3 - k))) & 32'hFF);
        exp_q.push_back({ea, eb});
        ref_mem[ea] = eb;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    int waited;
    waited = 0;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_be    = b;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited < 20), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic expect_lanes(input logic [3:0] b);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("lane_we", 32'(bus.mem_we), 32'(b[3-k]));
      check("lane_done", 32'(bus.done), 32'(k == 3));
      check("busy_ready", 32'(bus.req_ready), 32'd0);
    end
  endtask

  task automatic expect_idle(input logic [7:0] last_a, input logic [7:0] last_d);
    @(negedge clk);
    check("idle_we", 32'(bus.mem_we), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_err", 32'(bus.err), 32'd0);
    check("idle_addr_hold", 32'(bus.mem_addr), 32'(last_a));
    check("idle_wdata_hold", 32'(bus.mem_wdata), 32'(last_d));
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic full_req(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    model_push(a, d, b);
    issue(a, d, b);
    bus.req_valid = 1'b0;
    expect_lanes(b);
    expect_idle(8'((int'(a) + 3) % 256), d[7:0]);
    check("readback", dut_word(a), ref_word(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd, rd2;
    logic [3:0]  rb;
    int          acc1;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_data  = 32'h0;
    bus.req_be    = 4'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // No request: nothing moves.
    repeat (3) @(negedge clk);
    check("quiet_we", 32'(bus.mem_we), 32'd0);
    check("quiet_addr", 32'(bus.mem_addr), 32'd0);

    full_req(8'h10, 32'hDEADBEEF, 4'b1111);
    check("readback_deadbeef", dut_word(8'h10), 32'hDEADBEEF);
    full_req(8'h20, 32'h11223344, 4'b1010);

`ifdef MEM_WRITER_ALIGN_CHK_EN
    issue(8'hFE, 32'hCAFEF00D, 4'b1111);
    bus.req_valid = 1'b0;
    check("unal_err", 32'(bus.err), 32'd1);
    check("unal_we", 32'(bus.mem_we), 32'd0);
    check("unal_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("unal_err_pulse", 32'(bus.err), 32'd0);
    check("unal_done", 32'(bus.done), 32'd0);
    check("unal_no_write", dut_word(8'hFE), ref_word(8'hFE));
`else
    full_req(8'hFE, 32'hCAFEF00D, 4'b1111);
    check("wrap_lo", {tb_mem[8'h00], tb_mem[8'h01]}, 32'h0000F00D);
`endif

    full_req(8'h30, 32'h55667788, 4'b0000);

    // Two queued words with req_valid held high.
    rd  = $urandom;
    rd2 = $urandom;
    model_push(8'h50, rd, 4'b1111);
    issue(8'h50, rd, 4'b1111);
    acc1 = acc_cyc;
    model_push(8'h54, rd2, 4'b1111);
    bus.req_data = rd2;
    bus.req_addr = 8'h54;
    expect_lanes(4'b1111);
    issue(8'h54, rd2, 4'b1111);
    check("b2b_interval", 32'(acc_cyc - acc1), 32'd5);
    bus.req_valid = 1'b0;
    expect_lanes(4'b1111);
    expect_idle(8'h57, rd2[7:0]);
    check("b2b_word0", dut_word(8'h50), rd);
    check("b2b_word1", dut_word(8'h54), rd2);

    // Asynchronous reset in the middle of B1.
    model_push(8'h40, 32'hAABBCCDD, 4'b1000);
    issue(8'h40, 32'hAABBCCDD, 4'b1111);
    bus.req_valid = 1'b0;
    check("mid_b0_we", 32'(bus.mem_we), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(bus.mem_we), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd1);
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("arst_word", dut_word(8'h40), ref_word(8'h40));
    check("arst_byte0", 32'(tb_mem[8'h40]), 32'hAA);

    // Random requests.
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
`ifdef MEM_WRITER_ALIGN_CHK_EN
      ra[1:0] = 2'b00;
`endif
      rd = $urandom;
      rb = 4'($urandom_range(0, 15));
      full_req(ra, rd, rb);
    end

    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
